switch_egress_port: RTL

Output-side buffer of the 3-port switch: one instance per output port, fed by the crossbar/megamux lane that the scheduler enables for that port. Captures each byte granted to the port, checks its destination tag, and queues it in a small first-word-fall-through FIFO. Drains the queue to the port's link with a valid/ready handshake, and reports fill level back to the scheduler as backpressure.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/switch_fifo_fwft.sv | 53 +++++
 rtl/switch_egress_port.sv | 82 ++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared port codes, byte width and queue entry type for the switch
package switch_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] PORT_NONE = 2'b00;
    localparam logic [1:0] PORT_1    = 2'b01;
    localparam logic [1:0] PORT_2    = 2'b10;
    localparam logic [1:0] PORT_3    = 2'b11;

    typedef struct packed {
        logic [1:0]        src;
        logic [BYTE_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/switch_fifo_fwft.sv
// rtl/switch_fifo_fwft.sv - parameterised first-word-fall-through FIFO with extended pointers
module switch_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full queue is only legal when the head leaves this cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer advance; reset empties the queue at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are meaningless until covered by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/switch_egress_port.sv
// rtl/switch_egress_port.sv - egress buffer: tag check, queue, drain handshake and backpressure
module switch_egress_port
    import switch_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [1:0] PORT_ID  = PORT_1,
    parameter int         AF_LEVEL = DEPTH - 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        sel,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              almost_full,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        misroute_cnt
);

    localparam int AW = $clog2(DEPTH);

    entry_t      w_wentry;
    entry_t      w_rentry;
    logic        w_empty;
    logic        w_full;
    logic [AW:0] w_count;
    logic        w_tag_ok;
    logic        w_misroute;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [7:0]  r_drop_cnt;
    logic [7:0]  r_misroute_cnt;

    assign w_tag_ok   = (sel != PORT_NONE) && (data[1:0] == PORT_ID);
    assign w_misroute = en && !w_tag_ok;
    assign w_pop      = !w_empty && out_ready;
    assign w_push     = en && w_tag_ok && (!w_full || w_pop);
    assign w_drop     = en && w_tag_ok && w_full && !w_pop;

    assign w_wentry = '{src: sel, data: data};

    switch_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rentry),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Status flags decode only from the FIFO pointer registers.
    assign out_valid    = !w_empty;
    assign out_data     = w_rentry.data;
    assign out_src      = w_rentry.src;
    assign full         = w_full;
    assign almost_full  = (int'(w_count) >= AF_LEVEL);
    assign drop_cnt     = r_drop_cnt;
    assign misroute_cnt = r_misroute_cnt;

    // Loss counters; a bad tag never also counts as a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt     <= 8'd0;
            r_misroute_cnt <= 8'd0;
        end else begin
            if (w_misroute) r_misroute_cnt <= sat_inc(r_misroute_cnt);
            if (w_drop)     r_drop_cnt     <= sat_inc(r_drop_cnt);
        end
    end

endmodule
